// File: rtl/irq_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_pkg
// Description : Shared register map, channel encodings and default channel
//               count for the interrupt front-end.
// Revision    : 1.0 - initial release
// ============================================================================
package irq_ctrl_pkg;

    // Width of the CPU control unit irq vector; the front-end defaults to it.
    localparam int CPU_IRQ_CH = 8;
    localparam int IRQ_CH     = CPU_IRQ_CH;

    localparam int IRQ_DATA_W = 32;
    localparam int IRQ_ADDR_W = 2;

    typedef enum logic [IRQ_ADDR_W-1:0] {
        IRQ_ADDR_PEND = 2'd0,
        IRQ_ADDR_MODE = 2'd1,
        IRQ_ADDR_POL  = 2'd2,
        IRQ_ADDR_RAW  = 2'd3
    } irq_addr_e;

    localparam logic IRQ_MODE_LEVEL = 1'b0;
    localparam logic IRQ_MODE_EDGE  = 1'b1;
    localparam logic IRQ_POL_HIGH   = 1'b0;
    localparam logic IRQ_POL_LOW    = 1'b1;

endpackage
`default_nettype wire

// File: rtl/irq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl_if
// Description : Single-cycle request / registered-ack register access port.
// Revision    : 1.0 - initial release
// ============================================================================
interface irq_ctrl_if;
    import irq_ctrl_pkg::*;

    logic                  req;
    logic                  we;
    logic [IRQ_ADDR_W-1:0] addr;
    logic [IRQ_DATA_W-1:0] wdata;
    logic [IRQ_DATA_W-1:0] rdata;
    logic                  ack;

    modport master (
        output req,
        output we,
        output addr,
        output wdata,
        input  rdata,
        input  ack
    );

    modport slave (
        input  req,
        input  we,
        input  addr,
        input  wdata,
        output rdata,
        output ack
    );

endinterface
`default_nettype wire

// File: rtl/irq_sync.sv
`default_nettype none
// ============================================================================
// Module      : irq_sync
// Description : Per-bit multi-flop synchroniser for asynchronous inputs.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_sync #(
    parameter int WIDTH  = 8,
    parameter int STAGES = 2
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic [WIDTH-1:0] d_i,
    output logic      [WIDTH-1:0] q_o
);

    logic [STAGES-1:0][WIDTH-1:0] sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q <= '0;
        end else begin
            sync_q[0] <= d_i;
            for (int s = 1; s < STAGES; s++) begin
                sync_q[s] <= sync_q[s-1];
            end
        end
    end

    assign q_o = sync_q[STAGES-1];

endmodule
`default_nettype wire

// File: rtl/irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : irq_ctrl
// Description : Interrupt front-end: synchronise, normalise polarity, latch
//               edge/level events into PEND and expose a register port.
// Revision    : 1.0 - initial release
// ============================================================================
module irq_ctrl
    import irq_ctrl_pkg::*;
#(
    parameter int CH          = IRQ_CH,
    parameter int SYNC_STAGES = 2
) (
    input  wire logic          clk,
    input  wire logic          reset,
    input  wire logic [CH-1:0] irq_in_i,
    output logic      [CH-1:0] irq_out_o,
    irq_ctrl_if.slave          bus
);

    logic [CH-1:0]         w_sync;
    logic [CH-1:0]         w_norm;
    logic [CH-1:0]         w_rise;
    logic [CH-1:0]         w_clr;
    logic [CH-1:0]         w_wdata;
    logic                  w_wr;
    logic                  w_rd;

    logic [CH-1:0]         pend_q, pend_d;
    logic [CH-1:0]         mode_q, mode_d;
    logic [CH-1:0]         pol_q,  pol_d;
    logic [CH-1:0]         prev_q, prev_d;
    logic                  ack_q,  ack_d;
    logic [IRQ_DATA_W-1:0] rdata_q, rdata_d;

    irq_sync #(
        .WIDTH  (CH),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clk   (clk),
        .reset (reset),
        .d_i   (irq_in_i),
        .q_o   (w_sync)
    );

    assign w_norm  = w_sync ^ pol_q;
    assign w_rise  = w_norm & ~prev_q;
    assign w_wr    = bus.req &  bus.we;
    assign w_rd    = bus.req & ~bus.we;
    assign w_wdata = bus.wdata[CH-1:0];

    generate
        if (CH < IRQ_DATA_W) begin : g_wdata_hi
            logic w_unused_wdata_hi;
            assign w_unused_wdata_hi = ^bus.wdata[IRQ_DATA_W-1:CH];
        end
    endgenerate

    always_comb begin
        mode_d = mode_q;
        pol_d  = pol_q;
        w_clr  = '0;
        prev_d = w_norm;
        if (w_wr) begin
            case (irq_addr_e'(bus.addr))
                IRQ_ADDR_PEND: w_clr  = w_wdata;
                IRQ_ADDR_MODE: mode_d = w_wdata;
                IRQ_ADDR_POL: begin
                    pol_d  = w_wdata;
                    // Re-base the edge history on the new polarity so the flip is not seen as an edge.
                    prev_d = w_sync ^ w_wdata;
                end
                default: ;
            endcase
        end
    end

    // Set wins over a same-cycle W1C so a fresh edge is never lost.
    always_comb begin
        pend_d = pend_q;
        for (int i = 0; i < CH; i++) begin
            if (mode_q[i] == IRQ_MODE_EDGE) begin
                pend_d[i] = w_rise[i] | (pend_q[i] & ~w_clr[i]);
            end else begin
                pend_d[i] = w_norm[i];
            end
        end
    end

    always_comb begin
        ack_d   = bus.req;
        rdata_d = '0;
        if (w_rd) begin
            case (irq_addr_e'(bus.addr))
                IRQ_ADDR_PEND: rdata_d[CH-1:0] = pend_q;
                IRQ_ADDR_MODE: rdata_d[CH-1:0] = mode_q;
                IRQ_ADDR_POL:  rdata_d[CH-1:0] = pol_q;
                IRQ_ADDR_RAW:  rdata_d[CH-1:0] = w_norm;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pend_q  <= '0;
            mode_q  <= '0;
            pol_q   <= '0;
            prev_q  <= '0;
            ack_q   <= 1'b0;
            rdata_q <= '0;
        end else begin
            pend_q  <= pend_d;
            mode_q  <= mode_d;
            pol_q   <= pol_d;
            prev_q  <= prev_d;
            ack_q   <= ack_d;
            rdata_q <= rdata_d;
        end
    end

    // An access already in flight when reset rises is not acknowledged.
    assign bus.ack   = ack_q & ~reset;
    assign bus.rdata = reset ? '0 : rdata_q;
    assign irq_out_o = pend_q;

endmodule
`default_nettype wire

// File: tb/tb_irq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_irq_ctrl
// Description : Directed scoreboard bench for irq_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_irq_ctrl;
    import irq_ctrl_pkg::*;

    localparam int CH = 8;

    logic          clk    = 1'b0;
    logic          reset  = 1'b1;
    logic [CH-1:0] irq_in = '0;
    logic [CH-1:0] irq_out;
    int            cyc    = 0;
    int            checks = 0;
    int            failures = 0;

    typedef struct {
        logic [31:0] rdata;
        int          cyc;
        string       name;
    } exp_t;

    exp_t sbq[$];

    irq_ctrl_if bus ();

    irq_ctrl #(
        .CH          (CH),
        .SYNC_STAGES (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .irq_in_i  (irq_in),
        .irq_out_o (irq_out),
        .bus       (bus.slave)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    // One bus access: response expected on the cycle after acceptance.
    task automatic bus_op(input logic we, input logic [1:0] a, input logic [31:0] wd,
                          input logic [31:0] exp, input string name);
        bus.req   = 1'b1;
        bus.we    = we;
        bus.addr  = a;
        bus.wdata = wd;
        sbq.push_back('{rdata: exp, cyc: cyc + 1, name: name});
        @(negedge clk);
        bus.req   = 1'b0;
        bus.we    = 1'b0;
    endtask

    // Monitor: pops an expectation whenever ack is seen.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            #1;
            if (bus.ack === 1'b1) begin
                if (sbq.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_ack: got ack=1 rdata=0x%08h expected ack=0", bus.rdata);
                end else begin
                    e = sbq.pop_front();
                    chk({e.name, "_rdata"}, bus.rdata, e.rdata);
                    chk({e.name, "_ack_cycle"}, cyc, e.cyc);
                end
            end else if (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
                e = sbq.pop_front();
                checks++;
                failures++;
                $display("FAIL %s_ack: got ack=0 at cycle %0d expected ack=1 at cycle %0d", e.name, cyc, e.cyc);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish before 200000");
        $fatal(1, "timeout");
    end

    initial begin
        bus.req   = 1'b0;
        bus.we    = 1'b0;
        bus.addr  = '0;
        bus.wdata = '0;
        tick(3);
        reset = 1'b0;

        chk("reset_irq_out", irq_out, 0);
        bus_op(0, IRQ_ADDR_PEND, 0, 0, "rst_pend");
        bus_op(0, IRQ_ADDR_MODE, 0, 0, "rst_mode");
        bus_op(0, IRQ_ADDR_POL,  0, 0, "rst_pol");
        bus_op(0, IRQ_ADDR_RAW,  0, 0, "rst_raw");

        // Level mode latency in both directions
        irq_in[0] = 1'b1;
        tick(2);
        chk("lvl_rise_early", irq_out, 0);
        tick(1);
        chk("lvl_rise", irq_out, 32'h01);
        bus_op(0, IRQ_ADDR_RAW, 0, 32'h01, "rd_raw_lvl");
        irq_in[0] = 1'b0;
        tick(2);
        chk("lvl_fall_early", irq_out, 32'h01);
        tick(1);
        chk("lvl_fall", irq_out, 0);

        // Edge capture, hold and W1C
        bus_op(1, IRQ_ADDR_MODE, 32'h01, 0, "wr_mode1");
        irq_in[0] = 1'b1;
        tick(1);
        irq_in[0] = 1'b0;
        tick(4);
        chk("edge_set", irq_out, 32'h01);
        tick(3);
        chk("edge_hold", irq_out, 32'h01);
        bus_op(1, IRQ_ADDR_PEND, 32'h01, 0, "w1c_pend");
        chk("edge_clr", irq_out, 0);
        bus_op(0, IRQ_ADDR_PEND, 0, 0, "rd_pend_clr");

        // Rise on ch2 lands in the W1C acceptance cycle
        bus_op(1, IRQ_ADDR_MODE, 32'h05, 0, "wr_mode5");
        irq_in[2] = 1'b1;
        tick(2);
        bus_op(1, IRQ_ADDR_PEND, 32'h04, 0, "w1c_collide");
        chk("collide_irq_out", irq_out, 32'h04);
        bus_op(0, IRQ_ADDR_PEND, 0, 32'h04, "rd_pend_collide");
        bus_op(1, IRQ_ADDR_PEND, 32'h04, 0, "w1c_ch2");
        bus_op(0, IRQ_ADDR_PEND, 0, 0, "rd_pend_w1c");
        irq_in = '0;
        tick(4);

        // Polarity inversion without spurious edges, then active-low edge
        bus_op(1, IRQ_ADDR_MODE, 32'hFF, 0, "wr_mode_ff");
        irq_in = 8'hFF;
        bus_op(1, IRQ_ADDR_POL, 32'hFF, 0, "wr_pol_ff");
        tick(4);
        chk("pol_no_edge", irq_out, 0);
        bus_op(0, IRQ_ADDR_RAW, 0, 0, "rd_raw_inv");
        bus_op(0, IRQ_ADDR_POL, 0, 32'hFF, "rd_pol");
        irq_in[7] = 1'b0;
        tick(3);
        chk("pol_low_edge", irq_out, 32'h80);
        bus_op(0, IRQ_ADDR_PEND, 0, 32'h80, "rd_pend_80");

        // Back-to-back write then read, upper write bits ignored
        bus_op(1, IRQ_ADDR_MODE, 32'hDEADBEA5, 0, "b2b_wr_mode");
        bus_op(0, IRQ_ADDR_MODE, 0, 32'h000000A5, "b2b_rd_mode");

        // Build PEND=0x3C, then reset one cycle after a request
        bus_op(1, IRQ_ADDR_MODE, 32'hFF, 0, "wr_mode_ff2");
        bus_op(1, IRQ_ADDR_POL, 32'h00, 0, "wr_pol_0");
        irq_in = '0;
        tick(4);
        bus_op(1, IRQ_ADDR_PEND, 32'hFF, 0, "w1c_all");
        chk("pre_rst_clear", irq_out, 0);
        irq_in = 8'h3C;
        tick(4);
        chk("pre_rst_pend", irq_out, 32'h3C);

        bus.req  = 1'b1;
        bus.we   = 1'b0;
        bus.addr = IRQ_ADDR_PEND;
        @(negedge clk);
        bus.req  = 1'b0;
        reset    = 1'b1;
        irq_in   = '0;
        #1;
        chk("rst_ack_drop", {31'd0, bus.ack}, 0);
        @(negedge clk);
        chk("rst_irq_out", irq_out, 0);
        chk("rst_ack_after", {31'd0, bus.ack}, 0);
        reset = 1'b0;
        bus_op(0, IRQ_ADDR_PEND, 0, 0, "post_rst_pend");
        bus_op(0, IRQ_ADDR_MODE, 0, 0, "post_rst_mode");

        tick(3);
        chk("sb_drained", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
